// File: rtl/minv_req_collect.sv
// Host-side initiator for the modular-inverse engine: loads a 256-bit
// operand word-serially, starts the engine and gathers its result stream.
module minv_req_collect #(
    parameter int WORD_W  = 32,
    parameter int NWORDS  = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [WORD_W*NWORDS-1:0]   req_a,
    output logic                       ld_we,
    output logic [$clog2(NWORDS)-1:0]  ld_idx,
    output logic [WORD_W-1:0]          ld_data,
    output logic                       minv_en,
    input  logic                       minv_has_done,
    input  logic                       minv_out_valid,
    input  logic [WORD_W-1:0]          minv_out_data,
    output logic                       minv_out_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WORD_W*NWORDS-1:0]   rsp_data,
    output logic                       rsp_err
);

    localparam int CW = $clog2(NWORDS);
    localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        COLLECT = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t                      state_q;
    state_t                      state_d;
    logic [CW-1:0]               cnt_q;
    logic [15:0]                 tmo_q;
    logic [WORD_W*NWORDS-1:0]    a_q;
    logic [WORD_W*NWORDS-1:0]    rsp_data_q;
    logic                        rsp_err_q;
    logic                        run_q;
    logic                        tmo_hit;
    logic                        accept;

    // tmo_q counts WAIT cycles already spent, so a hit closes the last one
    assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TMO_LAST);
    assign accept  = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = LOAD;
            end
            LOAD: begin
                if (cnt_q == LAST) state_d = START;
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (minv_out_valid) state_d = COLLECT;
                else if (tmo_hit)   state_d = RESP;
            end
            COLLECT: begin
                if (!minv_out_valid || cnt_q == LAST) state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = 1'b0;
        ld_we          = 1'b0;
        ld_idx         = '0;
        ld_data        = '0;
        minv_en        = 1'b0;
        minv_out_ready = 1'b0;
        rsp_valid      = 1'b0;
        unique case (1'b1)
            state_q == IDLE: begin
                req_ready = run_q & minv_has_done;
            end
            state_q == LOAD: begin
                ld_we   = 1'b1;
                ld_idx  = cnt_q;
                ld_data = a_q[int'(cnt_q)*WORD_W +: WORD_W];
            end
            state_q == START: begin
                minv_en = 1'b1;
            end
            state_q == WAIT: begin
                minv_out_ready = 1'b1;
            end
            state_q == RESP: begin
                rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // run_q keeps req_ready low until the first clocked cycle after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            a_q        <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q   <= req_a;
                        cnt_q <= '0;
                    end
                end
                LOAD: begin
                    cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
                end
                START: begin
                    tmo_q <= '0;
                end
                WAIT: begin
                    if (tmo_q != 16'hFFFF) tmo_q <= tmo_q + 16'd1;
                    if (minv_out_valid) begin
                        rsp_data_q[WORD_W-1:0] <= minv_out_data;
                        rsp_err_q              <= 1'b0;
                        cnt_q                  <= CW'(1);
                    end else if (tmo_hit) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (minv_out_valid) begin
                        rsp_data_q[int'(cnt_q)*WORD_W +: WORD_W] <= minv_out_data;
                        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
                    end else begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                        cnt_q      <= '0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_err_q  <= 1'b0;
                        rsp_data_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule
